// File: rtl/debounce_edge.sv
// ---------------------------------------------------------------------------
// debounce_edge
//
// Conditions a raw, asynchronous, possibly bouncing single-bit input before it
// reaches downstream storage. The input is first brought into the clk domain
// through a plain flop chain, then a stability counter requires the
// synchronised value to disagree with the current output for STABLE_CYCLES
// consecutive cycles before the output follows it. Each accepted change also
// produces a single-cycle rise or fall strobe.
//
// Ports:
//   clk    - system clock, every state update happens on its rising edge
//   reset  - synchronous, active-high reset
//   d      - raw asynchronous input
//   q      - debounced level (registered)
//   rise   - one-cycle strobe when q goes 0->1 (registered)
//   fall   - one-cycle strobe when q goes 1->0 (registered)
//   busy   - high while a candidate change is being qualified (cnt != 0)
// ---------------------------------------------------------------------------
module debounce_edge #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall,
    output logic busy
);

    // The counter only ever has to reach STABLE_CYCLES-1, so this width is
    // always enough and the increment can never wrap.
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_q;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_s;

    // Synchronised view of d; only the last flop of the chain is ever used.
    assign w_s = r_sync[SYNC_STAGES-1];

    // Synchroniser chain: a pure shift register with nothing between stages
    // so each flop gets a full cycle to resolve metastability.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d};
        end
    end

    // Qualifier: count consecutive cycles where the synchronised input
    // disagrees with q. Any cycle of agreement clears the count, so an
    // interrupted run never carries credit into the next one. On the final
    // qualifying cycle q takes the new value and exactly one strobe fires.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_q    <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else if (w_s == r_q) begin
            r_cnt  <= '0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt  <= '0;
            r_q    <= w_s;
            r_rise <= w_s;
            r_fall <= ~w_s;
        end else begin
            r_cnt  <= r_cnt + CNT_ONE;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end
    end

    assign q    = r_q;
    assign rise = r_rise;
    assign fall = r_fall;
    // Derived only from the counter register, so there is no path from d.
    assign busy = (r_cnt != '0);

endmodule

// File: tb/tb_debounce_edge.sv
// ---------------------------------------------------------------------------
// tb_debounce_edge
//
// Self-checking bench for debounce_edge. Instance A uses the default
// parameters and is driven from a cycle-by-cycle vector table covering reset,
// clean steps, glitch rejection and reset priority, followed by hand-written
// bounce and boundary sequences. Instance B uses STABLE_CYCLES=1,
// SYNC_STAGES=3 to exercise the short-window latency and pulse pass-through.
// ---------------------------------------------------------------------------
module tb_debounce_edge;

    logic clk;
    logic rstA, dA, qA, riseA, fallA, busyA;
    logic rstB, dB, qB, riseB, fallB, busyB;

    int nCompared;
    int nMismatched;
    int edgeNum;

    // Strobe bookkeeping, updated once per clock after outputs settle.
    int riseCntA, fallCntA, riseEdgeA, fallEdgeA, overlapA;
    int riseCntB, fallCntB, riseEdgeB, fallEdgeB, overlapB;

    typedef struct {
        logic       rst;
        logic       d;
        logic [3:0] exp;   // {q, rise, fall, busy}
    } vec_t;

    vec_t vecs[$];

    debounce_edge dutA (
        .clk   (clk),
        .reset (rstA),
        .d     (dA),
        .q     (qA),
        .rise  (riseA),
        .fall  (fallA),
        .busy  (busyA)
    );

    debounce_edge #(
        .SYNC_STAGES   (3),
        .STABLE_CYCLES (1)
    ) dutB (
        .clk   (clk),
        .reset (rstB),
        .d     (dB),
        .q     (qB),
        .rise  (riseB),
        .fall  (fallB),
        .busy  (busyB)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock, then sample outputs 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        edgeNum++;
        if (riseA) begin riseCntA++; riseEdgeA = edgeNum; end
        if (fallA) begin fallCntA++; fallEdgeA = edgeNum; end
        if (riseA && fallA) overlapA++;
        if (riseB) begin riseCntB++; riseEdgeB = edgeNum; end
        if (fallB) begin fallCntB++; fallEdgeB = edgeNum; end
        if (riseB && fallB) overlapB++;
    endtask

    task automatic clearWatch();
        riseCntA = 0; fallCntA = 0; riseEdgeA = -1; fallEdgeA = -1; overlapA = 0;
        riseCntB = 0; fallCntB = 0; riseEdgeB = -1; fallEdgeB = -1; overlapB = 0;
    endtask

    task automatic applyStimulus(input logic rst, input logic dIn);
        rstA = rst;
        dA   = dIn;
        tick();
    endtask

    task automatic checkOutput(input string name, input int idx,
                               input int actual, input int expected);
        nCompared++;
        if (actual != expected) begin
            nMismatched++;
            $display("[TB] FAIL %s (step %0d): got %0d, expected %0d",
                     name, idx, actual, expected);
        end
    endtask

    task automatic addVec(input logic rst, input logic dIn, input logic [3:0] exp);
        vec_t v;
        v.rst = rst;
        v.d   = dIn;
        v.exp = exp;
        vecs.push_back(v);
    endtask

    initial begin
        int settle;
        int p;
        int n;
        int m;

        nCompared   = 0;
        nMismatched = 0;
        edgeNum     = 0;
        rstA = 1'b1; dA = 1'b0;
        rstB = 1'b1; dB = 1'b0;
        clearWatch();

        // Vector table: inputs applied before an edge, {q,rise,fall,busy}
        // expected just after it.
        // Reset state.
        addVec(1, 0, 4'b0000);
        addVec(1, 0, 4'b0000);
        // Clean rising step: d high before edge N=2, q follows at N+5.
        addVec(0, 1, 4'b0000);
        addVec(0, 1, 4'b0000);
        addVec(0, 1, 4'b0001);
        addVec(0, 1, 4'b0001);
        addVec(0, 1, 4'b0001);
        addVec(0, 1, 4'b1100);
        addVec(0, 1, 4'b1000);
        // Clean falling step.
        addVec(0, 0, 4'b1000);
        addVec(0, 0, 4'b1000);
        addVec(0, 0, 4'b1001);
        addVec(0, 0, 4'b1001);
        addVec(0, 0, 4'b1001);
        addVec(0, 0, 4'b0010);
        addVec(0, 0, 4'b0000);
        // Glitch: three cycles high reaches cnt=3 but never qualifies.
        addVec(0, 1, 4'b0000);
        addVec(0, 1, 4'b0000);
        addVec(0, 1, 4'b0001);
        addVec(0, 0, 4'b0001);
        addVec(0, 0, 4'b0001);
        addVec(0, 0, 4'b0000);
        addVec(0, 0, 4'b0000);
        // Rise, then reset flush with d still high, then fresh rise at +6.
        addVec(0, 1, 4'b0000);
        addVec(0, 1, 4'b0000);
        addVec(0, 1, 4'b0001);
        addVec(0, 1, 4'b0001);
        addVec(0, 1, 4'b0001);
        addVec(0, 1, 4'b1100);
        addVec(0, 1, 4'b1000);
        addVec(0, 1, 4'b1000);
        addVec(1, 1, 4'b0000);
        addVec(0, 1, 4'b0000);
        addVec(0, 1, 4'b0000);
        addVec(0, 1, 4'b0001);
        addVec(0, 1, 4'b0001);
        addVec(0, 1, 4'b0001);
        addVec(0, 1, 4'b1100);
        addVec(0, 1, 4'b1000);
        // Reset wins over a qualifying fall on the same edge.
        addVec(0, 0, 4'b1000);
        addVec(0, 0, 4'b1000);
        addVec(0, 0, 4'b1001);
        addVec(0, 0, 4'b1001);
        addVec(0, 0, 4'b1001);
        addVec(1, 0, 4'b0000);
        addVec(0, 0, 4'b0000);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].d);
            checkOutput("vec_q",    i, int'(qA),    int'(vecs[i].exp[3]));
            checkOutput("vec_rise", i, int'(riseA), int'(vecs[i].exp[2]));
            checkOutput("vec_fall", i, int'(fallA), int'(vecs[i].exp[1]));
            checkOutput("vec_busy", i, int'(busyA), int'(vecs[i].exp[0]));
        end

        // Bounce burst: ten cycles of toggling, then settle high.
        clearWatch();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, (i % 2) == 0);
        end
        settle = edgeNum + 1;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 1'b1);
        end
        checkOutput("bounce_rise_count", 0, riseCntA, 1);
        checkOutput("bounce_rise_edge", 0, riseEdgeA, settle + 5);
        checkOutput("bounce_fall_count", 0, fallCntA, 0);
        checkOutput("bounce_q_final", 0, int'(qA), 1);

        // Boundary: exactly four synchronised cycles high, then low.
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        clearWatch();
        p = edgeNum + 1;
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0);
        checkOutput("boundary_rise_count", 0, riseCntA, 1);
        checkOutput("boundary_rise_edge", 0, riseEdgeA, p + 5);
        checkOutput("boundary_fall_count", 0, fallCntA, 1);
        checkOutput("boundary_fall_edge", 0, fallEdgeA, p + 9);
        checkOutput("boundary_q_final", 0, int'(qA), 0);
        checkOutput("boundary_busy_final", 0, int'(busyA), 0);
        checkOutput("strobe_overlap_A", 0, overlapA, 0);

        // Short-window instance: step latency and one-cycle pulse pass-through.
        rstB = 1'b0; dB = 1'b0;
        tick();
        tick();
        clearWatch();
        dB = 1'b1;
        n = edgeNum + 1;
        for (int i = 0; i < 5; i++) tick();
        checkOutput("sweep_step_rise_edge", 0, riseEdgeB, n + 3);
        checkOutput("sweep_step_rise_count", 0, riseCntB, 1);
        checkOutput("sweep_step_q", 0, int'(qB), 1);
        dB = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checkOutput("sweep_step_fall_count", 0, fallCntB, 1);
        clearWatch();
        dB = 1'b1;
        m = edgeNum + 1;
        tick();
        dB = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        checkOutput("sweep_pulse_rise_edge", 0, riseEdgeB, m + 3);
        checkOutput("sweep_pulse_fall_edge", 0, fallEdgeB, m + 4);
        checkOutput("sweep_pulse_rise_count", 0, riseCntB, 1);
        checkOutput("sweep_pulse_fall_count", 0, fallCntB, 1);
        checkOutput("sweep_q_final", 0, int'(qB), 0);
        checkOutput("sweep_busy", 0, int'(busyB), 0);
        checkOutput("strobe_overlap_B", 0, overlapB, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
